// File: rtl/rrat.sv
// Retirement RAT: committed architectural-to-physical register map and the
// committed PRF free list. Up to `N instructions retire per cycle in program
// order (slot 0 oldest); each retiring destination displaces the previous
// committed tag, which is returned to the free list and reported for one cycle
// on free_vector_from_rrat.
//
// Optional feature: define RRAT_CHECK_EN to build the consistency checker that
// drives the sticky rrat_err flag. Without it, rrat_err is tied low.

`ifndef N
`define N 2
`endif
`ifndef RAT_SIZE
`define RAT_SIZE 32
`endif
`ifndef REG_INDEX_BITS
`define REG_INDEX_BITS 5
`endif
`ifndef PRF_NUM_ENTRIES
`define PRF_NUM_ENTRIES 64
`endif
`ifndef PRF_NUM_INDEX_BITS
`define PRF_NUM_INDEX_BITS 6
`endif

module rrat (
  input  logic                                                  clock,
  input  logic                                                  reset,
  input  logic [`N-1:0]                                         retire_valid,
  input  logic [`N-1:0]                                         retire_dest_valid,
  input  logic [`N-1:0][`REG_INDEX_BITS-1:0]                    retire_arch_dest,
  input  logic [`N-1:0][`PRF_NUM_INDEX_BITS-1:0]                retire_phys_dest,
  output logic [`RAT_SIZE-1:0][`PRF_NUM_INDEX_BITS-1:0]         rrat_entries,
  output logic [`PRF_NUM_ENTRIES-1:0]                           rrat_free_list,
  output logic [`PRF_NUM_ENTRIES-1:0]                           free_vector_from_rrat,
  output logic [`PRF_NUM_INDEX_BITS:0]                          free_count,
  output logic                                                  rrat_err
);

  localparam int unsigned NumSlots = `N;
  localparam int unsigned NumArch  = `RAT_SIZE;
  localparam int unsigned NumPrf   = `PRF_NUM_ENTRIES;
  localparam int unsigned TagW     = `PRF_NUM_INDEX_BITS;
  localparam int unsigned ArchW    = `REG_INDEX_BITS;
  localparam int unsigned CountW   = `PRF_NUM_INDEX_BITS + 1;

  // Reset image of the free list: every tag free except tag 0, which backs
  // the hard-wired zero register and is never allocated or released.
  localparam logic [NumPrf-1:0] FreeReset = {{(NumPrf-1){1'b1}}, 1'b0};
  localparam logic [CountW-1:0] CountReset = CountW'(NumPrf - 1);

  // Committed state
  logic [NumArch-1:0][TagW-1:0] map_q, map_d;
  logic [NumPrf-1:0]            free_q, free_d;
  logic [NumPrf-1:0]            fvec_q, fvec_d;
  logic [CountW-1:0]            count_q, count_d;

  // Per-slot qualification
  logic [NumSlots-1:0]          slot_active;

  // A slot only commits if every older slot in the group is also valid; a
  // write to arch r0 is discarded since r0 is never renamed.
  always_comb begin
    logic chain;
    chain       = 1'b1;
    slot_active = '0;
    for (int i = 0; i < NumSlots; i++) begin
      chain          = chain & retire_valid[i];
      slot_active[i] = chain & retire_dest_valid[i] & (retire_arch_dest[i] != '0);
    end
  end

  // Apply active slots in program order so a younger slot sees the map and
  // free list as already updated by older slots in the same group. This is
  // what lets two same-cycle writes to one arch reg release the older tag.
  always_comb begin
    logic [TagW-1:0]  old_tag;
    logic [TagW-1:0]  new_tag;
    logic [ArchW-1:0] arch;
    map_d   = map_q;
    free_d  = free_q;
    fvec_d  = '0;
    old_tag = '0;
    new_tag = '0;
    arch    = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (slot_active[i]) begin
        arch          = retire_arch_dest[i];
        new_tag       = retire_phys_dest[i];
        old_tag       = map_d[arch];
        map_d[arch]   = new_tag;
        free_d[new_tag] = 1'b0;
        if (old_tag != '0) begin
          free_d[old_tag] = 1'b1;
          fvec_d[old_tag] = 1'b1;
        end
      end
    end
    // Tag 0 is never handed back, whatever the retire stream says.
    free_d[0] = 1'b0;
    fvec_d[0] = 1'b0;
  end

  // Popcount of the next free list so free_count lines up with the
  // registered rrat_free_list in the same cycle.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < NumPrf; i++) begin
      count_d = count_d + CountW'(free_d[i]);
    end
  end

  // Committed state registers; reset wins over any concurrent retires.
  always_ff @(posedge clock) begin
    if (reset) begin
      map_q   <= '0;
      free_q  <= FreeReset;
      fvec_q  <= '0;
      count_q <= CountReset;
    end else begin
      map_q   <= map_d;
      free_q  <= free_d;
      fvec_q  <= fvec_d;
      count_q <= count_d;
    end
  end

`ifdef RRAT_CHECK_EN
  logic err_q, err_d;
  logic chk_hit;

  // Flag an active slot binding tag 0 or a tag the committed free list (as
  // updated by older slots this cycle) does not hold as free.
  always_comb begin
    logic [NumPrf-1:0] free_run;
    logic [NumArch-1:0][TagW-1:0] map_run;
    logic [TagW-1:0] tag;
    logic [TagW-1:0] prev;
    free_run = free_q;
    map_run  = map_q;
    chk_hit  = 1'b0;
    tag      = '0;
    prev     = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (slot_active[i]) begin
        tag = retire_phys_dest[i];
        if ((tag == '0) || !free_run[tag]) begin
          chk_hit = 1'b1;
        end
        prev                         = map_run[retire_arch_dest[i]];
        map_run[retire_arch_dest[i]] = tag;
        free_run[tag]                = 1'b0;
        if (prev != '0) begin
          free_run[prev] = 1'b1;
        end
      end
    end
    err_d = err_q | chk_hit;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign rrat_err = err_q;
`else
  assign rrat_err = 1'b0;
`endif

  assign rrat_entries          = map_q;
  assign rrat_free_list        = free_q;
  assign free_vector_from_rrat = fvec_q;
  assign free_count            = count_q;

endmodule

// File: tb/tb_rrat.sv
// Directed bench for rrat (N=2, 32 arch regs, 64 PRF tags). Each vector pushes
// its hand-computed expected committed state onto a scoreboard queue tagged
// with the cycle it must appear in; a negedge monitor pops and compares.

`ifndef N
`define N 2
`endif
`ifndef RAT_SIZE
`define RAT_SIZE 32
`endif
`ifndef REG_INDEX_BITS
`define REG_INDEX_BITS 5
`endif
`ifndef PRF_NUM_ENTRIES
`define PRF_NUM_ENTRIES 64
`endif
`ifndef PRF_NUM_INDEX_BITS
`define PRF_NUM_INDEX_BITS 6
`endif

module tb_rrat;

`ifdef RRAT_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  typedef logic [`RAT_SIZE-1:0][`PRF_NUM_INDEX_BITS-1:0] map_t;

  typedef struct {
    int                            id;
    int                            due;
    map_t                          map;
    logic [`PRF_NUM_ENTRIES-1:0]   fl;
    logic [`PRF_NUM_ENTRIES-1:0]   fv;
    logic [`PRF_NUM_INDEX_BITS:0]  cnt;
    logic                          err;
  } exp_t;

  logic                                            clock;
  logic                                            reset;
  logic [`N-1:0]                                   retire_valid;
  logic [`N-1:0]                                   retire_dest_valid;
  logic [`N-1:0][`REG_INDEX_BITS-1:0]              retire_arch_dest;
  logic [`N-1:0][`PRF_NUM_INDEX_BITS-1:0]          retire_phys_dest;
  map_t                                            rrat_entries;
  logic [`PRF_NUM_ENTRIES-1:0]                     rrat_free_list;
  logic [`PRF_NUM_ENTRIES-1:0]                     free_vector_from_rrat;
  logic [`PRF_NUM_INDEX_BITS:0]                    free_count;
  logic                                            rrat_err;

  rrat dut (
    .clock                 (clock),
    .reset                 (reset),
    .retire_valid          (retire_valid),
    .retire_dest_valid     (retire_dest_valid),
    .retire_arch_dest      (retire_arch_dest),
    .retire_phys_dest      (retire_phys_dest),
    .rrat_entries          (rrat_entries),
    .rrat_free_list        (rrat_free_list),
    .free_vector_from_rrat (free_vector_from_rrat),
    .free_count            (free_count),
    .rrat_err              (rrat_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  // Hand-maintained expected committed state
  map_t                        exp_map;
  logic [`PRF_NUM_ENTRIES-1:0] exp_free;
  logic                        exp_err;

  task automatic chk(input int id, input string name, input logic [191:0] act,
                     input logic [191:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL v%0d %s: got %h expected %h", id, name, act, req);
  endtask

  // Monitor: compare whatever expectation is due in the current cycle.
  always @(negedge clock) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.id, "rrat_entries", 192'(rrat_entries), 192'(e.map));
      chk(e.id, "rrat_free_list", 192'(rrat_free_list), 192'(e.fl));
      chk(e.id, "free_vector", 192'(free_vector_from_rrat), 192'(e.fv));
      chk(e.id, "free_count", 192'(free_count), 192'(e.cnt));
      chk(e.id, "rrat_err", 192'(rrat_err), 192'(e.err));
    end
  end

  // Drive one cycle of retire inputs (called #1 after a posedge) and push the
  // expected state that must be visible after the next posedge.
  task automatic step(input int id, input logic rst, input logic [1:0] rv,
                      input logic [1:0] dv, input logic [4:0] a0, input logic [5:0] p0,
                      input logic [4:0] a1, input logic [5:0] p1,
                      input logic [63:0] fv, input logic [6:0] cnt);
    exp_t e;
    reset                = rst;
    retire_valid         = rv;
    retire_dest_valid    = dv;
    retire_arch_dest[0]  = a0;
    retire_phys_dest[0]  = p0;
    retire_arch_dest[1]  = a1;
    retire_phys_dest[1]  = p1;
    e.id  = id;
    e.due = cyc + 1;
    e.map = exp_map;
    e.fl  = exp_free;
    e.fv  = fv;
    e.cnt = cnt;
    e.err = exp_err;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic set_reset_state();
    exp_map  = '0;
    exp_free = 64'hFFFF_FFFF_FFFF_FFFE;
    exp_err  = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    retire_valid      = '0;
    retire_dest_valid = '0;
    retire_arch_dest  = '0;
    retire_phys_dest  = '0;
    repeat (2) @(posedge clock);
    #1;

    // Reset then idle
    set_reset_state();
    step(0, 1'b1, 2'b00, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 64'h0, 7'd63);
    step(1, 1'b0, 2'b00, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 64'h0, 7'd63);

    // r5 -> p10, nothing released (old tag 0)
    exp_map[5] = 6'd10;
    exp_free   = 64'hFFFF_FFFF_FFFF_FBFE;
    step(2, 1'b0, 2'b01, 2'b01, 5'd5, 6'd10, 5'd0, 6'd0, 64'h0, 7'd62);
    step(3, 1'b0, 2'b00, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 64'h0, 7'd62);

    // r5 -> p11 releases p10 for exactly one cycle
    exp_map[5] = 6'd11;
    exp_free   = 64'hFFFF_FFFF_FFFF_F7FE;
    step(4, 1'b0, 2'b01, 2'b01, 5'd5, 6'd11, 5'd0, 6'd0, 64'h400, 7'd62);
    step(5, 1'b0, 2'b00, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 64'h0, 7'd62);

    // Same-cycle double write to r3: p20 released immediately
    exp_map[3] = 6'd21;
    exp_free   = 64'hFFFF_FFFF_FFDF_F7FE;
    step(6, 1'b0, 2'b11, 2'b11, 5'd3, 6'd20, 5'd3, 6'd21, 64'h10_0000, 7'd61);

    // Slot 1 valid behind invalid slot 0, r0 write, no dest: all ignored
    step(7, 1'b0, 2'b10, 2'b11, 5'd4, 6'd7, 5'd4, 6'd7, 64'h0, 7'd61);
    step(8, 1'b0, 2'b01, 2'b01, 5'd0, 6'd30, 5'd0, 6'd0, 64'h0, 7'd61);
    step(9, 1'b0, 2'b01, 2'b00, 5'd9, 6'd30, 5'd0, 6'd0, 64'h0, 7'd61);

    // Two independent writes in one group
    exp_map[1] = 6'd2;
    exp_map[2] = 6'd3;
    exp_free   = 64'hFFFF_FFFF_FFDF_F7F2;
    step(10, 1'b0, 2'b11, 2'b11, 5'd1, 6'd2, 5'd2, 6'd3, 64'h0, 7'd59);

    // r6 -> p11 while p11 is not free: checker fires if built
    exp_map[6] = 6'd11;
    exp_err    = ChkEn;
    step(11, 1'b0, 2'b01, 2'b01, 5'd6, 6'd11, 5'd0, 6'd0, 64'h0, 7'd59);
    step(12, 1'b0, 2'b00, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 64'h0, 7'd59);

    // Two slots each release a different old tag (p11 and p21)
    exp_map[5] = 6'd40;
    exp_map[3] = 6'd41;
    exp_free   = 64'hFFFF_FCFF_FFFF_FFF2;
    step(13, 1'b0, 2'b11, 2'b11, 5'd5, 6'd40, 5'd3, 6'd41, 64'h20_0800, 7'd59);

    // Reset beats a concurrent retire
    set_reset_state();
    step(14, 1'b1, 2'b01, 2'b01, 5'd5, 6'd12, 5'd0, 6'd0, 64'h0, 7'd63);
    step(15, 1'b0, 2'b00, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 64'h0, 7'd63);

    repeat (4) @(posedge clock);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      $display("FAIL v%0d scoreboard: expectation never checked, due cycle %0d now %0d",
               e.id, e.due, cyc);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
